button_debounce: RTL and testbench



---
 rtl/button_debounce.sv | 145 ++++++++++++++
 tb/tb_button_debounce.sv | 139 +++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Per-button two-flop synchroniser, debouncer and press/release/long-press detector.
// Output level and strobes are registered; each bit qualifies independently.
module button_debounce #(
   parameter int WIDTH             = 4,
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int LONG_PRESS_CYCLES = 50000000
) (
   input  logic             top_clkin_50,
   input  logic             top_internal_reset_n,
   input  logic [WIDTH-1:0] button_n_in,
   output logic [WIDTH-1:0] button_n_out,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] release_pulse,
   output logic [WIDTH-1:0] long_press
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_PRESS_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED   = 2'd0,
      PRESS_PEND = 2'd1,
      PRESSED    = 2'd2,
      REL_PEND   = 2'd3
   } state_t;

   logic [WIDTH-1:0] sync_meta;
   logic [WIDTH-1:0] sync_s;

   // Reset to 1 so an idle (released) button never looks like a press.
   always_ff @(posedge top_clkin_50 or negedge top_internal_reset_n) begin
      if (!top_internal_reset_n) begin
         sync_meta <= '1;
         sync_s    <= '1;
      end else begin
         sync_meta <= button_n_in;
         sync_s    <= sync_meta;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      state_t            state, state_nxt;
      logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
      logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
      logic [HOLD_W-1:0] hold_inc;
      logic              hold_hit;
      logic              s;
      logic              level, level_nxt;
      logic              press, press_nxt;
      logic              rel, rel_nxt;
      logic              lng, lng_nxt;

      assign s        = sync_s[i];
      assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);
      assign hold_hit = (hold_cnt == HOLD_PRE);

      always_ff @(posedge top_clkin_50 or negedge top_internal_reset_n) begin
         if (!top_internal_reset_n) begin
            state    <= RELEASED;
            db_cnt   <= '0;
            hold_cnt <= '0;
            level    <= 1'b1;
            press    <= 1'b0;
            rel      <= 1'b0;
            lng      <= 1'b0;
         end else begin
            state    <= state_nxt;
            db_cnt   <= db_cnt_nxt;
            hold_cnt <= hold_cnt_nxt;
            level    <= level_nxt;
            press    <= press_nxt;
            rel      <= rel_nxt;
            lng      <= lng_nxt;
         end
      end

      always_comb begin
         state_nxt    = state;
         db_cnt_nxt   = db_cnt;
         hold_cnt_nxt = hold_cnt;
         level_nxt    = level;
         press_nxt    = 1'b0;
         rel_nxt      = 1'b0;
         lng_nxt      = lng;
         case (state)
            RELEASED: begin
               if (!s) begin
                  state_nxt  = PRESS_PEND;
                  db_cnt_nxt = DB_W'(1);
               end
            end
            PRESS_PEND: begin
               if (s) begin
                  state_nxt  = RELEASED;
                  db_cnt_nxt = '0;
               end else if (db_cnt == DB_LAST) begin
                  state_nxt    = PRESSED;
                  level_nxt    = 1'b0;
                  press_nxt    = 1'b1;
                  hold_cnt_nxt = '0;
               end else begin
                  db_cnt_nxt = db_cnt + DB_W'(1);
               end
            end
            PRESSED: begin
               hold_cnt_nxt = hold_inc;
               if (hold_hit) lng_nxt = 1'b1;
               if (s) begin
                  state_nxt  = REL_PEND;
                  db_cnt_nxt = DB_W'(1);
               end
            end
            REL_PEND: begin
               // Hold time keeps accruing so a release bounce does not reset long-press timing.
               hold_cnt_nxt = hold_inc;
               if (hold_hit) lng_nxt = 1'b1;
               if (!s) begin
                  state_nxt = PRESSED;
               end else if (db_cnt == DB_LAST) begin
                  state_nxt    = RELEASED;
                  level_nxt    = 1'b1;
                  rel_nxt      = 1'b1;
                  lng_nxt      = 1'b0;
                  hold_cnt_nxt = '0;
               end else begin
                  db_cnt_nxt = db_cnt + DB_W'(1);
               end
            end
            default: begin
               state_nxt = RELEASED;
            end
         endcase
      end

      assign button_n_out[i]  = level;
      assign press_pulse[i]   = press;
      assign release_pulse[i] = rel;
      assign long_press[i]    = lng;
   end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32.
module tb_button_debounce;

   logic       top_clkin_50 = 1'b0;
   logic       top_internal_reset_n = 1'b0;
   logic [3:0] button_n_in = 4'hF;
   logic [3:0] button_n_out;
   logic [3:0] press_pulse;
   logic [3:0] release_pulse;
   logic [3:0] long_press;

   int total = 0;
   int bad   = 0;

   logic [3:0] prev_out = 4'hF;
   logic [3:0] prev_lng = 4'h0;

   typedef struct {
      logic [3:0] btn;
      int         edges;
      logic [3:0] out;
      logic [3:0] prs;
      logic [3:0] rel;
      logic [3:0] lng;
   } step_t;

   step_t steps[$];

   button_debounce #(
      .WIDTH(4),
      .DEBOUNCE_CYCLES(8),
      .LONG_PRESS_CYCLES(32)
   ) dut (
      .top_clkin_50(top_clkin_50),
      .top_internal_reset_n(top_internal_reset_n),
      .button_n_in(button_n_in),
      .button_n_out(button_n_out),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse),
      .long_press(long_press)
   );

   always #5 top_clkin_50 = ~top_clkin_50;

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Strobes must only appear on the final edge of a step; level outputs hold until then.
   task automatic run_step(input string tag, input step_t st);
      button_n_in = st.btn;
      for (int e = 0; e < st.edges; e++) begin
         @(posedge top_clkin_50);
         #1;
         if (e == st.edges - 1) begin
            check4($sformatf("%s out", tag), button_n_out, st.out);
            check4($sformatf("%s press", tag), press_pulse, st.prs);
            check4($sformatf("%s release", tag), release_pulse, st.rel);
            check4($sformatf("%s long", tag), long_press, st.lng);
         end else begin
            check4($sformatf("%s e%0d out", tag, e), button_n_out, prev_out);
            check4($sformatf("%s e%0d press", tag, e), press_pulse, 4'h0);
            check4($sformatf("%s e%0d release", tag, e), release_pulse, 4'h0);
            check4($sformatf("%s e%0d long", tag, e), long_press, prev_lng);
         end
      end
      prev_out = st.out;
      prev_lng = st.lng;
   endtask

   initial begin
      // idle
      steps.push_back('{4'hF, 50, 4'hF, 4'h0, 4'h0, 4'h0});
      // bit0 clean press, held 20, then released
      steps.push_back('{4'hE, 10, 4'hE, 4'h1, 4'h0, 4'h0});
      steps.push_back('{4'hE, 10, 4'hE, 4'h0, 4'h0, 4'h0});
      steps.push_back('{4'hF, 10, 4'hF, 4'h0, 4'h1, 4'h0});
      steps.push_back('{4'hF,  5, 4'hF, 4'h0, 4'h0, 4'h0});
      // bit1 bounce train, then stable press and release
      steps.push_back('{4'hD,  5, 4'hF, 4'h0, 4'h0, 4'h0});
      steps.push_back('{4'hF,  2, 4'hF, 4'h0, 4'h0, 4'h0});
      steps.push_back('{4'hD,  5, 4'hF, 4'h0, 4'h0, 4'h0});
      steps.push_back('{4'hF,  3, 4'hF, 4'h0, 4'h0, 4'h0});
      steps.push_back('{4'hD, 10, 4'hD, 4'h2, 4'h0, 4'h0});
      steps.push_back('{4'hF, 10, 4'hF, 4'h0, 4'h2, 4'h0});
      steps.push_back('{4'hF,  5, 4'hF, 4'h0, 4'h0, 4'h0});
      // bit2 long press: press at edge 9, long at edge 41, held 60, release
      steps.push_back('{4'hB, 10, 4'hB, 4'h4, 4'h0, 4'h0});
      steps.push_back('{4'hB, 32, 4'hB, 4'h0, 4'h0, 4'h4});
      steps.push_back('{4'hB, 18, 4'hB, 4'h0, 4'h0, 4'h4});
      steps.push_back('{4'hF, 10, 4'hF, 4'h0, 4'h4, 4'h0});
      steps.push_back('{4'hF,  5, 4'hF, 4'h0, 4'h0, 4'h0});
      // bits 0 and 3 together
      steps.push_back('{4'h6, 10, 4'h6, 4'h9, 4'h0, 4'h0});
      steps.push_back('{4'hF, 10, 4'hF, 4'h0, 4'h9, 4'h0});
      steps.push_back('{4'hF,  5, 4'hF, 4'h0, 4'h0, 4'h0});

      repeat (3) @(posedge top_clkin_50);
      #1;
      check4("reset out", button_n_out, 4'hF);
      check4("reset press", press_pulse, 4'h0);
      check4("reset release", release_pulse, 4'h0);
      check4("reset long", long_press, 4'h0);
      top_internal_reset_n = 1'b1;

      for (int i = 0; i < steps.size(); i++) begin
         run_step($sformatf("step%0d", i), steps[i]);
      end

      // reset while bit0 held: no release strobe, fresh press after deassertion
      run_step("rst press", '{4'hE, 10, 4'hE, 4'h1, 4'h0, 4'h0});
      run_step("rst hold", '{4'hE, 4, 4'hE, 4'h0, 4'h0, 4'h0});
      top_internal_reset_n = 1'b0;
      #2;
      check4("async rst out", button_n_out, 4'hF);
      check4("async rst press", press_pulse, 4'h0);
      check4("async rst release", release_pulse, 4'h0);
      check4("async rst long", long_press, 4'h0);
      for (int e = 0; e < 2; e++) begin
         @(posedge top_clkin_50);
         #1;
         check4($sformatf("in rst e%0d out", e), button_n_out, 4'hF);
         check4($sformatf("in rst e%0d release", e), release_pulse, 4'h0);
      end
      top_internal_reset_n = 1'b1;
      prev_out = 4'hF;
      prev_lng = 4'h0;
      run_step("post rst press", '{4'hE, 10, 4'hE, 4'h1, 4'h0, 4'h0});
      run_step("post rst release", '{4'hF, 10, 4'hF, 4'h0, 4'h1, 4'h0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
